// File: rtl/prog_seq_pkg.sv
// Shared types and helpers for the program sequencer.
package prog_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Largest program table the sequencer supports.
  localparam int MAX_NPROG = 8;

  // Widest PC the relative-add helper can handle.
  localparam int MAX_L = 32;

  // Add a two's-complement offset of the given width to a base address.
  // The caller truncates the result to its own PC width, which gives the
  // modulo-2^L wrap in both directions.
  function automatic logic [MAX_L-1:0] sext_add(input logic [MAX_L-1:0] base,
                                                input logic [MAX_L-1:0] off,
                                                input int               width);
    logic [MAX_L-1:0] sign_mask;
    logic [MAX_L-1:0] ext;
    sign_mask = {{(MAX_L-1){1'b0}}, 1'b1} << (width - 1);
    ext       = off;
    if ((off & sign_mask) != '0) begin
      ext = off | ({MAX_L{1'b1}} << width);
    end
    return base + ext;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO: DEPTH entries of L bits with push, pop and flush.
// Push when full and pop when empty are dropped; pop wins over push.
module ret_stack
  import prog_seq_pkg::*;
#(
  parameter int L     = 10,
  parameter int DEPTH = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [L-1:0] push_data,
  output logic [L-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [L-1:0]  mem_q [DEPTH];
  logic [AW-1:0] top_idx;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign top_idx = cnt_q[AW-1:0] - AW'(1);
  assign top     = mem_q[top_idx];

  // Qualify requests against the fill level; flush overrides both.
  always_comb begin
    do_pop  = pop & ~empty & ~flush;
    do_push = push & ~pop & ~full & ~flush;
    cnt_d   = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (do_pop) begin
      cnt_d = cnt_q - CW'(1);
    end else if (do_push) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Fill-level register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; the slot at the current count is the next free one.
  always_ff @(posedge Clk) begin
    if (!Reset && do_push) begin
      mem_q[cnt_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/prog_seq_ctr.sv
// Program counter and sequencer: arms each program from its base address on
// Start, runs it with branch/call/return control, and advances on Done.
module prog_seq_ctr
  import prog_seq_pkg::*;
#(
  parameter int                         L         = 10,
  parameter int                         NPROG     = 3,
  parameter logic [0:NPROG-1][L-1:0]    PROG_BASE = {10'd50, 10'd150, 10'd250},
  parameter int                         DEPTH     = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic                       Done,
  input  logic                       BranchAbs,
  input  logic                       BranchRel,
  input  logic                       CondEn,
  input  logic                       AluFlag,
  input  logic                       Call,
  input  logic                       Ret,
  input  logic [L-1:0]               Target,
  output logic [L-1:0]               ProgCtr,
  output logic [$clog2(NPROG):0]     ProgIdx,
  output logic                       Running,
  output logic                       Finished,
  output logic                       StackErr
);

  localparam int IW = $clog2(NPROG) + 1;

  state_e        state_q, state_d;
  logic [L-1:0]  pc_q, pc_d;
  logic [IW-1:0] prog_idx_q, prog_idx_d;
  logic          finished_q, finished_d;
  logic          stack_err_q, stack_err_d;

  logic [L-1:0]  base_sel;
  logic [L-1:0]  pc_inc;
  logic          br_taken;
  logic          stk_push;
  logic          stk_pop;
  logic          stk_flush;
  logic [L-1:0]  stk_top;
  logic          stk_full;
  logic          stk_empty;

  assign ProgCtr  = pc_q;
  assign ProgIdx  = prog_idx_q;
  assign Running  = (state_q == ST_RUN);
  assign Finished = finished_q;
  assign StackErr = stack_err_q;

  assign pc_inc   = pc_q + L'(1);
  assign br_taken = ~CondEn | AluFlag;

  // Select the entry address of the program currently indexed.
  always_comb begin
    base_sel = '0;
    for (int i = 0; i < NPROG; i++) begin
      if (prog_idx_q == IW'(i)) begin
        base_sel = PROG_BASE[i];
      end
    end
  end

  ret_stack #(
    .L     (L),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (stk_push),
    .pop       (stk_pop),
    .flush     (stk_flush),
    .push_data (pc_inc),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // Next-state, next-PC and stack control. Done takes precedence over any
  // flow-control strobe in the same cycle so the final PC is preserved.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    prog_idx_d  = prog_idx_q;
    finished_d  = 1'b0;
    stack_err_d = stack_err_q;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_flush   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d     = ST_ARMED;
          pc_d        = base_sel;
          stk_flush   = 1'b1;
          stack_err_d = 1'b0;
        end
      end

      ST_ARMED: begin
        if (!Start) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (Done) begin
          state_d    = ST_IDLE;
          finished_d = 1'b1;
          prog_idx_d = (prog_idx_q == IW'(NPROG - 1)) ? '0 : prog_idx_q + IW'(1);
        end else if (Ret) begin
          if (stk_empty) begin
            pc_d        = pc_inc;
            stack_err_d = 1'b1;
          end else begin
            pc_d    = stk_top;
            stk_pop = 1'b1;
          end
        end else if (Call) begin
          if (stk_full) begin
            pc_d        = pc_inc;
            stack_err_d = 1'b1;
          end else begin
            pc_d     = Target;
            stk_push = 1'b1;
          end
        end else if (BranchAbs && br_taken) begin
          pc_d = Target;
        end else if (BranchRel && br_taken) begin
          pc_d = L'(sext_add(MAX_L'(pc_q), MAX_L'(Target), L));
        end else begin
          pc_d = pc_inc;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      prog_idx_q  <= '0;
      finished_q  <= 1'b0;
      stack_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      prog_idx_q  <= prog_idx_d;
      finished_q  <= finished_d;
      stack_err_q <= stack_err_d;
    end
  end

endmodule

// File: tb/tb_prog_seq_ctr.sv
// Self-checking bench for prog_seq_ctr: a queue-based reference model checked
// every cycle, plus literal expectations at key points of the sequence.
module tb_prog_seq_ctr;

  localparam int L     = 10;
  localparam int NPROG = 3;
  localparam int DEPTH = 4;
  localparam int IW    = $clog2(NPROG) + 1;
  localparam int PCMOD = 1 << L;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Start;
  logic          Done;
  logic          BranchAbs;
  logic          BranchRel;
  logic          CondEn;
  logic          AluFlag;
  logic          Call;
  logic          Ret;
  logic [L-1:0]  Target;
  logic [L-1:0]  ProgCtr;
  logic [IW-1:0] ProgIdx;
  logic          Running;
  logic          Finished;
  logic          StackErr;

  always #5 Clk = ~Clk;

  prog_seq_ctr #(
    .L         (L),
    .NPROG     (NPROG),
    .PROG_BASE ({10'd50, 10'd150, 10'd250}),
    .DEPTH     (DEPTH)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Done      (Done),
    .BranchAbs (BranchAbs),
    .BranchRel (BranchRel),
    .CondEn    (CondEn),
    .AluFlag   (AluFlag),
    .Call      (Call),
    .Ret       (Ret),
    .Target    (Target),
    .ProgCtr   (ProgCtr),
    .ProgIdx   (ProgIdx),
    .Running   (Running),
    .Finished  (Finished),
    .StackErr  (StackErr)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: mode 0 idle, 1 armed, 2 running.
  int m_pc   = 0;
  int m_idx  = 0;
  int m_mode = 0;
  bit m_err  = 1'b0;
  bit m_fin  = 1'b0;
  int m_stack[$];
  int bases[NPROG] = '{50, 150, 250};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task model_step();
    int off;
    m_fin = 1'b0;
    if (Reset) begin
      m_pc   = 0;
      m_idx  = 0;
      m_mode = 0;
      m_err  = 1'b0;
      m_stack.delete();
    end else if (m_mode == 0) begin
      if (Start) begin
        m_mode = 1;
        m_pc   = bases[m_idx];
        m_err  = 1'b0;
        m_stack.delete();
      end
    end else if (m_mode == 1) begin
      if (!Start) m_mode = 2;
    end else begin
      if (Done) begin
        m_mode = 0;
        m_fin  = 1'b1;
        m_idx  = (m_idx + 1) % NPROG;
      end else if (Ret) begin
        if (m_stack.size() == 0) begin
          m_pc  = (m_pc + 1) % PCMOD;
          m_err = 1'b1;
        end else begin
          m_pc = m_stack.pop_back();
        end
      end else if (Call) begin
        if (m_stack.size() == DEPTH) begin
          m_pc  = (m_pc + 1) % PCMOD;
          m_err = 1'b1;
        end else begin
          m_stack.push_back((m_pc + 1) % PCMOD);
          m_pc = int'(Target);
        end
      end else if ((BranchAbs || BranchRel) && (!CondEn || AluFlag)) begin
        if (BranchAbs) begin
          m_pc = int'(Target);
        end else begin
          off  = (int'(Target) >= PCMOD / 2) ? int'(Target) - PCMOD : int'(Target);
          m_pc = (m_pc + off + PCMOD) % PCMOD;
        end
      end else begin
        m_pc = (m_pc + 1) % PCMOD;
      end
    end
  endtask

  always @(posedge Clk) model_step();

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("ProgCtr",  32'(ProgCtr),  32'(m_pc));
      chk("ProgIdx",  32'(ProgIdx),  32'(m_idx));
      chk("Running",  32'(Running),  32'(m_mode == 2));
      chk("Finished", 32'(Finished), 32'(m_fin));
      chk("StackErr", 32'(StackErr), 32'(m_err));
    end
  end

  task automatic clr_in();
    Start     = 1'b0;
    Done      = 1'b0;
    BranchAbs = 1'b0;
    BranchRel = 1'b0;
    CondEn    = 1'b0;
    AluFlag   = 1'b0;
    Call      = 1'b0;
    Ret       = 1'b0;
    Target    = '0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  // Drive one flow-control strobe for a single cycle, then clear it.
  task automatic op(input bit abs, input bit rel, input bit cen, input bit flg,
                    input bit cl, input bit rt, input int tgt);
    BranchAbs = abs;
    BranchRel = rel;
    CondEn    = cen;
    AluFlag   = flg;
    Call      = cl;
    Ret       = rt;
    Target    = L'(tgt);
    tick();
    clr_in();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    clr_in();
    tick();
    chk_en = 1'b1;
    tick();
    Reset = 1'b0;
    chk("lit_rst_pc",  32'(ProgCtr),  0);
    chk("lit_rst_idx", 32'(ProgIdx),  0);
    chk("lit_rst_run", 32'(Running),  0);
    chk("lit_rst_err", 32'(StackErr), 0);

    // Program 0: arm for three cycles, then release.
    Start = 1'b1;
    tick();
    chk("lit_armed_pc", 32'(ProgCtr), 50);
    tick();
    tick();
    Start = 1'b0;
    tick();
    chk("lit_run_first", 32'(ProgCtr), 50);
    chk("lit_running",   32'(Running), 1);
    tick();
    chk("lit_run_inc", 32'(ProgCtr), 51);
    chk("lit_run_idx", 32'(ProgIdx), 0);

    // Branches.
    op(1, 0, 0, 0, 0, 0, 60);
    chk("lit_abs60", 32'(ProgCtr), 60);
    op(0, 1, 0, 0, 0, 0, 10'h3FB);
    chk("lit_rel_m5", 32'(ProgCtr), 55);
    op(0, 1, 1, 0, 0, 0, 10'h3FF);
    chk("lit_rel_nt", 32'(ProgCtr), 56);
    op(1, 0, 1, 1, 0, 0, 200);
    chk("lit_abs_cond", 32'(ProgCtr), 200);
    op(1, 0, 1, 0, 0, 0, 7);
    chk("lit_abs_nt", 32'(ProgCtr), 201);

    // Call / return.
    op(1, 0, 0, 0, 0, 0, 70);
    op(0, 0, 0, 0, 1, 0, 300);
    chk("lit_call", 32'(ProgCtr), 300);
    op(0, 0, 0, 0, 0, 1, 0);
    chk("lit_ret", 32'(ProgCtr), 71);

    // Five nested calls overflow a four-entry stack.
    for (int k = 0; k < 5; k++) op(0, 0, 0, 0, 1, 0, 400 + 10 * k);
    chk("lit_ovf_pc",  32'(ProgCtr),  431);
    chk("lit_ovf_err", 32'(StackErr), 1);
    for (int k = 0; k < 4; k++) op(0, 0, 0, 0, 0, 1, 0);
    chk("lit_unwind", 32'(ProgCtr), 72);
    op(0, 0, 0, 0, 0, 1, 0);
    chk("lit_unf_pc",  32'(ProgCtr),  73);
    chk("lit_unf_err", 32'(StackErr), 1);

    // Call and Ret together: Ret wins, no push.
    op(0, 0, 0, 0, 1, 0, 500);
    op(0, 0, 0, 0, 1, 1, 600);
    chk("lit_callret", 32'(ProgCtr), 74);
    op(0, 0, 0, 0, 0, 1, 0);
    chk("lit_callret_empty", 32'(ProgCtr), 75);

    // PC wrap boundaries.
    op(1, 0, 0, 0, 0, 0, 1023);
    tick();
    chk("lit_wrap", 32'(ProgCtr), 0);
    op(1, 0, 0, 0, 0, 0, 1023);
    op(0, 0, 0, 0, 1, 0, 5);
    op(0, 0, 0, 0, 0, 1, 0);
    chk("lit_call_wrap", 32'(ProgCtr), 0);
    op(0, 1, 0, 0, 0, 0, 10'h3FF);
    chk("lit_rel_wrap", 32'(ProgCtr), 1023);

    // Done ends program 0.
    Done = 1'b1;
    tick();
    chk("lit_fin",      32'(Finished), 1);
    chk("lit_fin_run",  32'(Running),  0);
    chk("lit_fin_pc",   32'(ProgCtr),  1023);
    chk("lit_fin_idx",  32'(ProgIdx),  1);
    tick();
    Done = 1'b0;
    chk("lit_done_idle", 32'(Finished), 0);

    // Program 1, with Done while armed and Start while running.
    Start = 1'b1;
    tick();
    chk("lit_base1",  32'(ProgCtr),  150);
    chk("lit_errclr", 32'(StackErr), 0);
    Done = 1'b1;
    tick();
    Done  = 1'b0;
    Start = 1'b0;
    tick();
    tick();
    chk("lit_p1_inc", 32'(ProgCtr), 151);
    Start = 1'b1;
    tick();
    chk("lit_start_ign", 32'(ProgCtr), 152);
    Start = 1'b0;
    Done  = 1'b1;
    tick();
    Done = 1'b0;
    chk("lit_idx2", 32'(ProgIdx), 2);

    // Program 2, then the index wraps back to 0.
    Start = 1'b1;
    tick();
    chk("lit_base2", 32'(ProgCtr), 250);
    Start = 1'b0;
    tick();
    Done = 1'b1;
    tick();
    Done = 1'b0;
    chk("lit_idx_wrap", 32'(ProgIdx), 0);
    Start = 1'b1;
    tick();
    chk("lit_base0_again", 32'(ProgCtr), 50);
    Start = 1'b0;
    tick();

    // Reset mid-run with Call and Done active.
    op(0, 0, 0, 0, 1, 0, 300);
    Call   = 1'b1;
    Target = L'(400);
    Done   = 1'b1;
    Reset  = 1'b1;
    tick();
    clr_in();
    Reset = 1'b0;
    chk("lit_mrst_pc",  32'(ProgCtr), 0);
    chk("lit_mrst_idx", 32'(ProgIdx), 0);
    chk("lit_mrst_run", 32'(Running), 0);
    chk("lit_mrst_fin", 32'(Finished), 0);
    Start = 1'b1;
    tick();
    chk("lit_post_rst", 32'(ProgCtr), 50);
    Start = 1'b0;
    tick();
    op(0, 0, 0, 0, 0, 1, 0);
    chk("lit_empty_after_rst", 32'(ProgCtr),  51);
    chk("lit_empty_err",       32'(StackErr), 1);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_seq_ctr.md
Name: prog_seq_ctr

Overview:
Parametrised program counter and program sequencer for the basic processor. Holds the fetch address and steps through NPROG programs at configurable base addresses, one program per Start pulse. Supports conditional and unconditional branches in absolute and PC-relative form, plus a bounded call/return stack. Sits between the control decoder (branch, call, return and done strobes) and instruction ROM (address).

Parameters:
L, 10, PC / instruction-address width
NPROG, 3, number of programs in the sequence (1..8)
PROG_BASE, {10'd50,10'd150,10'd250}, packed array [NPROG] of L-bit program entry addresses; element i is program i
DEPTH, 4, return-stack entries (power of 2, 2..16)

Ports:
Clk  in  1  clock; all state changes on posedge
Reset  in  1  synchronous, active-high
Start  in  1  level; hold to arm next program, release to run it
Done  in  1  current program finished (decoder halt), 1-cycle strobe
BranchAbs  in  1  jump to Target when taken
BranchRel  in  1  jump to PC + signed Target when taken
CondEn  in  1  1: branch taken only if AluFlag; 0: unconditional
AluFlag  in  1  ALU condition flag
Call  in  1  push PC+1, jump absolute to Target
Ret  in  1  pop stack into PC
Target  in  L  branch/call operand (two's complement for BranchRel)
ProgCtr  out  L  current fetch address
ProgIdx  out  $clog2(NPROG)+1  index of program armed/running
Running  out  1  1 in RUN state
Finished  out  1  pulses 1 cycle when Done accepted
StackErr  out  1  sticky overflow/underflow flag, cleared by Reset or next arm

Behaviour:
- Reset: ProgCtr=0, ProgIdx=0, state IDLE, stack empty, Running=0, Finished=0, StackErr=0. Reset overrides all inputs, including mid-program.
- States: IDLE -> (Start=1) ARMED -> (Start=0) RUN -> (Done=1) IDLE.
- IDLE: PC holds; all branch/call/ret inputs ignored.
- ARMED: ProgCtr=PROG_BASE[ProgIdx] (registered on entry); stack flushed; StackErr cleared; PC holds while Start stays high.
- RUN, first cycle after release: PC = base. Then one update per cycle with priority Ret > Call > BranchAbs > BranchRel > increment.
- Branch taken = BranchX & (~CondEn | AluFlag). Not taken -> PC+1.
- Rel target: PC + sign-extended Target, mod 2^L. Increment wraps from 2^L-1 to 0.
- Call: push PC+1 (mod 2^L); PC = Target.
  - Call when stack full: no push, PC = PC+1, StackErr=1.
- Ret: PC = top of stack; pop.
  - Ret when stack empty: PC = PC+1, StackErr=1.
- Call and Ret in the same cycle: Ret wins, and no push occurs.
- Done in RUN:
  - Next cycle: state IDLE, Finished=1 for one cycle, PC holds the last value.
  - ProgIdx increments; it wraps NPROG-1 -> 0.
- Done in IDLE/ARMED: ignored.
- Start high during RUN: ignored until Done returns the block to IDLE.
- Latency: every PC change is visible on ProgCtr 1 cycle after the controlling inputs.

Decomposition:
- Package prog_seq_pkg:
  - state enum (IDLE, ARMED, RUN)
  - max-NPROG constant
  - helper function for sign-extend add
- Sub-module ret_stack: LIFO with push/pop/flush, DEPTH x L.
  - Outputs: top, full, empty.
  - Push when full and pop when empty are ignored.

Test Plan:
- Reset, pulse Start 3 cycles then release -> ProgCtr 50 in ARMED, 51 two cycles after release, Running=1, ProgIdx=0.
- In RUN at PC 60: BranchRel Target=-5 uncond -> 55; CondEn=1 AluFlag=0 Target=0x3FF -> 56; BranchAbs Target=200 CondEn=1 AluFlag=1 -> 200.
- Call Target=300 at PC 70 -> 300, Ret -> 71. Five nested calls with DEPTH=4 -> fifth yields PC+1 and StackErr=1. Ret on empty stack -> PC+1, StackErr stays 1.
- Done at program 0 -> Finished pulse, IDLE. Second and third Start/Done rounds give bases 150 then 250; fourth Start -> 50 (ProgIdx wraps to 0).
- Assert Reset mid-RUN with Call+Done active -> next cycle ProgCtr=0, ProgIdx=0, IDLE, stack empty. Following Start -> 50.
- PC at 1023 with no branch -> 0; Call at 1023 pushes 0.
